// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
//   Shared types and constants for the stepper sequencer.
//   - step_state_t : sequencer FSM state (idle / running a move)
//   - phase_idx_t  : 3-bit position in the 8-entry half-step table
//   - COIL_TABLE   : coil drive pattern {A+,B+,A-,B-} per table position
//   - phase_advance: next table position for a given direction and step size
// -----------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_RUN
    } step_state_t;

    typedef logic [2:0] phase_idx_t;

    localparam logic [3:0] COIL_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // 3-bit arithmetic wraps modulo 8; a full step (+/-2) preserves parity.
    function automatic phase_idx_t phase_advance(input phase_idx_t idx,
                                                 input logic       up,
                                                 input logic       half);
        phase_idx_t delta;
        delta = half ? 3'd1 : 3'd2;
        return up ? phase_idx_t'(idx + delta) : phase_idx_t'(idx - delta);
    endfunction

endpackage

// File: rtl/stepper_sequencer.sv
// -----------------------------------------------------------------------------
// stepper_sequencer
//   Walks a 4-coil stepper motor through the half-step table, one entry per
//   tick from the step-rate counter, for a commanded number of steps.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   tick        in   one-cycle step pulse from the step-rate counter
//   start       in   command strobe (sampled only while idle)
//   dir         in   1: advance table index, 0: retreat (latched on start)
//   half_step   in   1: move by one entry, 0: move by two (latched on start)
//   steps       in   number of steps in the move (latched on start)
//   abort       in   terminate the current move (sampled only while running)
//   coils       out  registered coil drive {A+,B+,A-,B-}
//   busy        out  high while a move is in progress
//   done        out  one-cycle pulse on normal completion
//   steps_left  out  registered remaining step count
//   rate_reset  out  one-cycle pulse re-aligning the step-rate counter
// -----------------------------------------------------------------------------
module stepper_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_W      = 16,
    parameter bit          HOLD_TORQUE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              dir,
    input  logic              half_step,
    input  logic [STEP_W-1:0] steps,
    input  logic              abort,
    output logic [3:0]        coils,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic              rate_reset
);

    step_state_t       r_state;
    phase_idx_t        r_idx;
    logic              r_dir;
    logic              r_half;
    logic [3:0]        r_coils;
    logic              r_done;
    logic              r_rate_reset;
    logic [STEP_W-1:0] r_steps_left;

    phase_idx_t        w_idx_next;
    logic [STEP_W-1:0] w_left_dec;
    logic              w_last_step;
    logic [3:0]        w_park_cur;
    logic [3:0]        w_park_next;

    always_comb begin
        w_idx_next  = phase_advance(r_idx, r_dir, r_half);
        w_left_dec  = r_steps_left - STEP_W'(1);
        w_last_step = (w_left_dec == '0);
        // Coil pattern to park on when leaving RUN (abort vs. final step).
        w_park_cur  = HOLD_TORQUE ? COIL_TABLE[r_idx]      : 4'b0000;
        w_park_next = HOLD_TORQUE ? COIL_TABLE[w_idx_next] : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_coils      <= 4'b0000;
            r_done       <= 1'b0;
            r_rate_reset <= 1'b0;
            r_steps_left <= '0;
        end else begin
            r_done       <= 1'b0;
            r_rate_reset <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // tick is deliberately ignored here, even alongside start.
                    if (start) begin
                        if (steps != '0) begin
                            r_state      <= S_RUN;
                            r_rate_reset <= 1'b1;
                            r_steps_left <= steps;
                            r_coils      <= COIL_TABLE[r_idx];
                            r_dir        <= dir;
                            r_half       <= half_step;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_coils <= w_park_cur;
                    end else if (tick) begin
                        r_idx        <= w_idx_next;
                        r_steps_left <= w_left_dec;
                        if (w_last_step) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_coils <= w_park_next;
                        end else begin
                            r_coils <= COIL_TABLE[w_idx_next];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign coils      = r_coils;
    assign busy       = (r_state == S_RUN);
    assign done       = r_done;
    assign steps_left = r_steps_left;
    assign rate_reset = r_rate_reset;

endmodule

// File: tb/tb_stepper_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stepper_sequencer
//   Scoreboard bench for stepper_sequencer. A driver applies one input vector
//   per cycle at the falling edge and pushes the reference model's expected
//   post-edge outputs; a monitor pops and compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_stepper_sequencer;

    localparam int unsigned STEP_W = 16;
    localparam bit          HOLD   = 1'b0;
    localparam logic [3:0]  TBL [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    typedef struct packed {
        logic [3:0]        coils;
        logic              busy;
        logic              done;
        logic [STEP_W-1:0] left;
        logic              rr;
    } obs_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              tick = 1'b0;
    logic              start = 1'b0;
    logic              dir = 1'b0;
    logic              half_step = 1'b0;
    logic [STEP_W-1:0] steps = '0;
    logic              abort = 1'b0;
    logic [3:0]        coils;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;
    logic              rate_reset;

    stepper_sequencer #(
        .STEP_W     (STEP_W),
        .HOLD_TORQUE(HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .dir       (dir),
        .half_step (half_step),
        .steps     (steps),
        .abort     (abort),
        .coils     (coils),
        .busy      (busy),
        .done      (done),
        .steps_left(steps_left),
        .rate_reset(rate_reset)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];

    // Reference model: motor position as an integer 0..7, move length as int.
    bit         m_run;
    int         m_pos;
    int         m_left;
    bit         m_dir;
    bit         m_half;
    logic [3:0] m_coils;
    bit         m_done;
    bit         m_rr;
    bit         prev_rst = 1'b0;

    task automatic model_step();
        m_done = 1'b0;
        m_rr   = 1'b0;
        if (!reset) begin
            m_run = 0; m_pos = 0; m_left = 0; m_coils = 4'b0000;
        end else if (!m_run) begin
            if (start && steps != 0) begin
                m_run   = 1;
                m_rr    = 1;
                m_left  = int'(steps);
                m_coils = TBL[m_pos];
                m_dir   = dir;
                m_half  = half_step;
            end else if (start) begin
                m_done = 1;
            end
        end else if (abort) begin
            m_run   = 0;
            m_coils = HOLD ? TBL[m_pos] : 4'b0000;
        end else if (tick) begin
            m_pos   = (m_pos + (m_dir ? 1 : -1) * (m_half ? 1 : 2) + 8) % 8;
            m_left  = m_left - 1;
            m_coils = TBL[m_pos];
            if (m_left == 0) begin
                m_run   = 0;
                m_done  = 1;
                m_coils = HOLD ? TBL[m_pos] : 4'b0000;
            end
        end
        exp_q.push_back({m_coils, m_run, m_done, STEP_W'(m_left), m_rr});
    endtask

    task automatic drive(input logic rst, input logic st, input logic [STEP_W-1:0] n,
                         input logic d, input logic h, input logic tk, input logic ab);
        @(negedge clk);
        reset = rst; start = st; steps = n; dir = d; half_step = h; tick = tk; abort = ab;
        model_step();
        if (!rst && prev_rst) begin
            // Asynchronous reset must clear the coils well before the next edge.
            #1;
            n_checks++;
            if (coils !== 4'b0000 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL async_reset: coils=%b busy=%b, want coils=0000 busy=0",
                         coils, busy);
            end
        end
        prev_rst = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, '0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected observation per rising edge, compared 1 time unit later.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {coils, busy, done, steps_left, rate_reset};
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL outputs t=%0t: got coils=%b busy=%b done=%b left=%0d rr=%b, want coils=%b busy=%b done=%b left=%0d rr=%b",
                             $time, a.coils, a.busy, a.done, a.left, a.rr,
                             e.coils, e.busy, e.done, e.left, e.rr);
                end
            end
        end
    end

    initial begin
        // 1: reset held low while inputs toggle randomly.
        for (int i = 0; i < 4; i++)
            drive(0, 1'($urandom), STEP_W'($urandom_range(0, 5)), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        idle(2);

        // 2: three forward half steps from idx 0, ticks five cycles apart.
        drive(1, 1, 16'd3, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle(4);
            drive(1, 0, '0, 0, 0, 1, 0);
        end
        idle(3);

        // 3: re-home to idx 0, then two reverse full steps (0 -> 6 -> 4).
        drive(0, 0, '0, 0, 0, 0, 0);
        idle(2);
        drive(1, 1, 16'd2, 0, 0, 0, 0);
        idle(2);
        drive(1, 0, '0, 0, 0, 1, 0);
        drive(1, 0, '0, 0, 0, 1, 0);
        idle(3);

        // 4: five-step move aborted after two ticks; abort wins over a tick.
        drive(1, 1, 16'd5, 1, 1, 0, 0);
        drive(1, 0, '0, 0, 0, 1, 0);
        idle(1);
        drive(1, 0, '0, 0, 0, 1, 0);
        drive(1, 0, '0, 0, 0, 1, 1);
        idle(3);

        // 5: zero-length move, then start coincident with tick.
        drive(1, 1, 16'd0, 1, 1, 0, 0);
        idle(2);
        drive(1, 1, 16'd2, 0, 1, 1, 0);
        idle(1);
        drive(1, 0, '0, 0, 0, 1, 0);
        drive(1, 0, '0, 0, 0, 1, 0);
        idle(2);

        // 6: start while busy is ignored, then reset mid-move.
        drive(1, 1, 16'd4, 1, 0, 0, 0);
        drive(1, 0, '0, 0, 0, 1, 0);
        drive(1, 1, 16'd9, 0, 1, 0, 0);
        drive(1, 1, 16'd7, 0, 1, 1, 0);
        drive(0, 0, '0, 0, 0, 0, 0);
        idle(2);

        // Randomised traffic, including back-to-back ticks and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic [STEP_W-1:0] n;
            int                r;
            r = int'($urandom_range(0, 9));
            n = (r == 9) ? STEP_W'($urandom) : STEP_W'(r);
            drive(($urandom_range(0, 249) != 0), ($urandom_range(0, 5) == 0), n,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 49) == 0));
        end
        idle(2);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
